// File: rtl/bullet_pool.sv
// Bullet pool: N_SLOTS independent bullet slots with spawn/kill handshakes,
// a per-tick motion sweep (one slot per cycle) and two combinational read ports.

// One bullet slot: storage plus its own motion/boundary arithmetic.
module bullet_slot #(
  parameter int COORD_W = 8,
  parameter int VEL_W   = 5,
  parameter int X_MAX   = 200,
  parameter int Y_MAX   = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spawn,
  input  logic               kill,
  input  logic               step,
  input  logic [COORD_W-1:0] sx,
  input  logic [COORD_W-1:0] sy,
  input  logic [COORD_W-1:0] sw,
  input  logic [COORD_W-1:0] sh,
  input  logic [VEL_W-1:0]   svx,
  input  logic [VEL_W-1:0]   svy,
  input  logic [2:0]         scolor,
  input  logic               swrap,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] w,
  output logic [COORD_W-1:0] h,
  output logic [2:0]         color,
  output logic               active,
  output logic               despawn
);
  // Two guard bits: one for overflow past the max coordinate, one for sign.
  typedef logic signed [COORD_W+1:0] ext_t;

  localparam ext_t XLIM  = ext_t'(X_MAX);
  localparam ext_t YLIM  = ext_t'(Y_MAX);
  localparam ext_t XSPAN = ext_t'(X_MAX + 1);
  localparam ext_t YSPAN = ext_t'(Y_MAX + 1);

  logic [VEL_W-1:0]   vx, vy;
  logic               wrap;
  ext_t               nx, ny, nxw, nyw;
  logic               x_oob, y_oob, oob;
  logic [COORD_W-1:0] wx, wy;

  // Candidate next position, range check and wrapped position for both axes.
  always_comb begin
    nx    = ext_t'({2'b00, x}) + ext_t'($signed(vx));
    ny    = ext_t'({2'b00, y}) + ext_t'($signed(vy));
    x_oob = nx[COORD_W+1] || (nx > XLIM);
    y_oob = ny[COORD_W+1] || (ny > YLIM);
    oob   = x_oob || y_oob;
    nxw   = nx[COORD_W+1] ? nx + XSPAN : nx - XSPAN;
    nyw   = ny[COORD_W+1] ? ny + YSPAN : ny - YSPAN;
    wx    = x_oob ? nxw[COORD_W-1:0] : nx[COORD_W-1:0];
    wy    = y_oob ? nyw[COORD_W-1:0] : ny[COORD_W-1:0];
  end

  // Flags a boundary despawn this cycle; a simultaneous kill already accounts for it.
  assign despawn = step && active && !kill && oob && !wrap;

  // Spawn only ever targets an inactive slot, so it cannot collide with a real
  // kill; kill outranks the sweep step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0; y <= '0; w <= '0; h <= '0;
      vx <= '0; vy <= '0; color <= '0; wrap <= 1'b0; active <= 1'b0;
    end else if (spawn) begin
      x <= sx; y <= sy; w <= sw; h <= sh;
      vx <= svx; vy <= svy; color <= scolor; wrap <= swrap; active <= 1'b1;
    end else if (kill) begin
      active <= 1'b0;
    end else if (step && active) begin
      if (oob && !wrap) begin
        active <= 1'b0;
      end else begin
        x <= wx;
        y <= wy;
      end
    end
  end
endmodule

// Pool top: sweep FSM, free-slot allocation, kill decode, counters, read ports.
module bullet_pool #(
  parameter int N_SLOTS = 8,
  parameter int COORD_W = 8,
  parameter int VEL_W   = 5,
  parameter int X_MAX   = 200,
  parameter int Y_MAX   = 200,
  parameter int IDX_W   = $clog2(N_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 spawn_valid,
  output logic                 spawn_ready,
  input  logic [COORD_W-1:0]   spawn_x,
  input  logic [COORD_W-1:0]   spawn_y,
  input  logic [COORD_W-1:0]   spawn_w,
  input  logic [COORD_W-1:0]   spawn_h,
  input  logic [VEL_W-1:0]     spawn_vx,
  input  logic [VEL_W-1:0]     spawn_vy,
  input  logic [2:0]           spawn_color,
  input  logic                 spawn_wrap,
  input  logic                 kill_valid,
  input  logic [IDX_W-1:0]     kill_idx,
  input  logic [IDX_W-1:0]     rd_idx_a,
  input  logic [IDX_W-1:0]     rd_idx_b,
  output logic [2*COORD_W-1:0] pos_a,
  output logic [2*COORD_W-1:0] pos_b,
  output logic [2*COORD_W-1:0] size_a,
  output logic [2*COORD_W-1:0] size_b,
  output logic [2:0]           color_a,
  output logic [2:0]           color_b,
  output logic                 active_a,
  output logic                 active_b,
  output logic [IDX_W:0]       active_count,
  output logic                 overrun
);
  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                            state, state_nx;
  logic [IDX_W-1:0]                  cnt, cnt_nx;
  logic [N_SLOTS-1:0][COORD_W-1:0]   xs, ys, ws, hs;
  logic [N_SLOTS-1:0][2:0]           cols;
  logic [N_SLOTS-1:0]                act, spawn_sel, kill_sel, step_sel, desp;
  logic                              any_free, spawn_fire, kill_eff, desp_any;
  logic [IDX_W-1:0]                  free_idx;

  // Lowest-index inactive slot (scan downward so the last hit is the lowest).
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = N_SLOTS-1; i >= 0; i--) begin
      if (!act[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign spawn_ready = rst_n && (state == IDLE) && any_free;
  assign spawn_fire  = spawn_valid && spawn_ready;
  assign kill_eff    = kill_valid && act[kill_idx];
  assign desp_any    = |desp;

  // One-hot per-slot strobes for spawn target, kill target and sweep position.
  always_comb begin
    spawn_sel = '0;
    kill_sel  = '0;
    step_sel  = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      spawn_sel[i] = spawn_fire && (free_idx == IDX_W'(i));
      kill_sel[i]  = kill_valid && (kill_idx == IDX_W'(i));
      step_sel[i]  = (state == SWEEP) && (cnt == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    bullet_slot #(
      .COORD_W(COORD_W), .VEL_W(VEL_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .spawn  (spawn_sel[g]),
      .kill   (kill_sel[g]),
      .step   (step_sel[g]),
      .sx     (spawn_x),
      .sy     (spawn_y),
      .sw     (spawn_w),
      .sh     (spawn_h),
      .svx    (spawn_vx),
      .svy    (spawn_vy),
      .scolor (spawn_color),
      .swrap  (spawn_wrap),
      .x      (xs[g]),
      .y      (ys[g]),
      .w      (ws[g]),
      .h      (hs[g]),
      .color  (cols[g]),
      .active (act[g]),
      .despawn(desp[g])
    );
  end

  // Sweep state and slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: a tick starts a sweep of exactly N_SLOTS cycles.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nx = SWEEP;
          cnt_nx   = '0;
        end
      end
      SWEEP: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == IDX_W'(N_SLOTS-1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sticky flag for ticks that arrive while a sweep is still running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       overrun <= 1'b0;
    else if (state == SWEEP && tick)  overrun <= 1'b1;
  end

  // Occupancy tracks the active bits: +spawn, -effective kill, -despawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active_count <= '0;
    else        active_count <= active_count + {{IDX_W{1'b0}}, spawn_fire}
                                             - {{IDX_W{1'b0}}, kill_eff}
                                             - {{IDX_W{1'b0}}, desp_any};
  end

  assign pos_a    = {xs[rd_idx_a], ys[rd_idx_a]};
  assign size_a   = {ws[rd_idx_a], hs[rd_idx_a]};
  assign color_a  = cols[rd_idx_a];
  assign active_a = act[rd_idx_a];
  assign pos_b    = {xs[rd_idx_b], ys[rd_idx_b]};
  assign size_b   = {ws[rd_idx_b], hs[rd_idx_b]};
  assign color_b  = cols[rd_idx_b];
  assign active_b = act[rd_idx_b];
endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: reset, motion, despawn/wrap, allocation,
// overrun/kill during sweep, reset mid-sweep.
module tb_bullet_pool;
  localparam int N = 8, CW = 8, VW = 5, IW = 3;

  logic clk = 0, rst_n = 1, tick = 0, spawn_valid = 0, spawn_wrap = 0, kill_valid = 0;
  logic [CW-1:0] spawn_x = 0, spawn_y = 0, spawn_w = 8'd4, spawn_h = 8'd2;
  logic [VW-1:0] spawn_vx = 0, spawn_vy = 0;
  logic [2:0]    spawn_color = 0;
  logic [IW-1:0] kill_idx = 0, rd_idx_a = 0, rd_idx_b = 0;
  logic          spawn_ready, active_a, active_b, overrun;
  logic [2*CW-1:0] pos_a, pos_b, size_a, size_b;
  logic [2:0]    color_a, color_b;
  logic [IW:0]   active_count;

  int nchk = 0, nfail = 0;

  bullet_pool #(.N_SLOTS(N), .COORD_W(CW), .VEL_W(VW), .X_MAX(200), .Y_MAX(200)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_w(spawn_w), .spawn_h(spawn_h),
    .spawn_vx(spawn_vx), .spawn_vy(spawn_vy), .spawn_color(spawn_color), .spawn_wrap(spawn_wrap),
    .kill_valid(kill_valid), .kill_idx(kill_idx), .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
    .pos_a(pos_a), .pos_b(pos_b), .size_a(size_a), .size_b(size_b),
    .color_a(color_a), .color_b(color_b), .active_a(active_a), .active_b(active_b),
    .active_count(active_count), .overrun(overrun));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    tick = 0; spawn_valid = 0; kill_valid = 0; spawn_color = 0;
    rst_n = 0; cyc(2); rst_n = 1; cyc(1);
  endtask

  task automatic peek(input int k);
    rd_idx_a = IW'(k); #1;
  endtask

  task automatic do_tick;
    tick = 1; cyc(1); tick = 0;
  endtask

  task automatic kill1(input int k);
    kill_valid = 1; kill_idx = IW'(k); cyc(1); kill_valid = 0;
  endtask

  // Spawn with a bounded wait for ready; a timeout counts as a failed comparison.
  task automatic spawn1(input int x, input int y, input int vx, input int vy, input bit wrap);
    int n = 0;
    spawn_x = CW'(x); spawn_y = CW'(y); spawn_vx = VW'(vx); spawn_vy = VW'(vy);
    spawn_wrap = wrap; spawn_valid = 1;
    while (!spawn_ready && n < 20) begin cyc(1); n++; end
    if (!spawn_ready) begin
      nchk++; nfail++;
      $display("FAIL spawn_timeout: spawn_ready got %0b required 1", spawn_ready);
    end
    cyc(1); spawn_valid = 0;
  endtask

  task automatic test_reset;
    #2 rst_n = 0; #2;
    nchk++; if (active_count !== 4'd0) begin nfail++; $display("FAIL rst_count: got %0d required 0", active_count); end
    nchk++; if (spawn_ready !== 1'b0) begin nfail++; $display("FAIL rst_ready: got %0b required 0", spawn_ready); end
    nchk++; if (overrun !== 1'b0) begin nfail++; $display("FAIL rst_overrun: got %0b required 0", overrun); end
    nchk++; if (active_a !== 1'b0 || pos_a !== 16'h0) begin nfail++; $display("FAIL rst_slot: active %0b pos %h required 0/0000", active_a, pos_a); end
    cyc(2); rst_n = 1; #1;
    nchk++; if (spawn_ready !== 1'b1) begin nfail++; $display("FAIL rst_release_ready: got %0b required 1", spawn_ready); end
  endtask

  task automatic test_move;
    do_reset;
    spawn_color = 3'b001;
    spawn1(16, 19, 10, 0, 0);
    peek(0);
    nchk++; if (active_a !== 1'b1 || pos_a !== {8'd16, 8'd19}) begin nfail++; $display("FAIL move_spawn: active %0b pos %h required 1/1013", active_a, pos_a); end
    nchk++; if (size_a !== {8'd4, 8'd2} || color_a !== 3'b001) begin nfail++; $display("FAIL move_fields: size %h color %0d required 0402/1", size_a, color_a); end
    nchk++; if (active_count !== 4'd1) begin nfail++; $display("FAIL move_count0: got %0d required 1", active_count); end
    do_tick; cyc(8); peek(0);
    nchk++; if (pos_a !== {8'd26, 8'd19} || active_a !== 1'b1) begin nfail++; $display("FAIL move_pos: pos %h active %0b required 1a13/1", pos_a, active_a); end
    nchk++; if (active_count !== 4'd1) begin nfail++; $display("FAIL move_count1: got %0d required 1", active_count); end
  endtask

  task automatic test_boundary;
    do_reset;
    spawn1(195, 10, 10, 0, 0);
    spawn1(195, 10, 10, 0, 1);
    do_tick;
    cyc(1); peek(0);
    nchk++; if (active_a !== 1'b0 || pos_a !== {8'd195, 8'd10}) begin nfail++; $display("FAIL despawn: active %0b pos %h required 0/c30a", active_a, pos_a); end
    nchk++; if (active_count !== 4'd1) begin nfail++; $display("FAIL despawn_count: got %0d required 1", active_count); end
    cyc(1); peek(1);
    nchk++; if (active_a !== 1'b1 || pos_a !== {8'd4, 8'd10}) begin nfail++; $display("FAIL wrap_pos: active %0b pos %h required 1/040a", active_a, pos_a); end
    cyc(6);
    nchk++; if (active_count !== 4'd1 || spawn_ready !== 1'b1) begin nfail++; $display("FAIL boundary_end: count %0d ready %0b required 1/1", active_count, spawn_ready); end
  endtask

  task automatic test_wrap_neg;
    do_reset;
    spawn1(3, 5, -5, -6, 1);
    do_tick; cyc(8); peek(0);
    nchk++; if (pos_a !== {8'd199, 8'd200} || active_a !== 1'b1) begin nfail++; $display("FAIL wrap_neg: pos %h active %0b required c7c8/1", pos_a, active_a); end
  endtask

  task automatic test_full;
    do_reset;
    for (int k = 0; k < N; k++) spawn1(k * 10, 0, 0, 0, 0);
    nchk++; if (active_count !== 4'd8 || spawn_ready !== 1'b0) begin nfail++; $display("FAIL full: count %0d ready %0b required 8/0", active_count, spawn_ready); end
    // Hold a request while full, then free slot 5.
    spawn_x = 8'd88; spawn_valid = 1; cyc(3);
    nchk++; if (active_count !== 4'd8) begin nfail++; $display("FAIL hold_count: got %0d required 8", active_count); end
    kill_valid = 1; kill_idx = 3'd5; cyc(1); kill_valid = 0;
    nchk++; if (active_count !== 4'd7 || spawn_ready !== 1'b1) begin nfail++; $display("FAIL kill5: count %0d ready %0b required 7/1", active_count, spawn_ready); end
    cyc(1); spawn_valid = 0; peek(5);
    nchk++; if (active_a !== 1'b1 || pos_a[15:8] !== 8'd88) begin nfail++; $display("FAIL reuse5: active %0b x %0d required 1/88", active_a, pos_a[15:8]); end
    cyc(2);
    nchk++; if (active_count !== 4'd8 || spawn_ready !== 1'b0) begin nfail++; $display("FAIL no_dup: count %0d ready %0b required 8/0", active_count, spawn_ready); end
    // Kill 6 together with a spawn: the spawn must go to the already-free slot 3.
    kill1(3);
    spawn_x = 8'd99; spawn_valid = 1; kill_valid = 1; kill_idx = 3'd6; cyc(1);
    spawn_valid = 0; kill_valid = 0;
    peek(3);
    nchk++; if (active_a !== 1'b1 || pos_a[15:8] !== 8'd99) begin nfail++; $display("FAIL kill_spawn_tgt: active %0b x %0d required 1/99", active_a, pos_a[15:8]); end
    peek(6);
    nchk++; if (active_a !== 1'b0) begin nfail++; $display("FAIL kill_spawn_killed: active %0b required 0", active_a); end
    nchk++; if (active_count !== 4'd7) begin nfail++; $display("FAIL kill_spawn_count: got %0d required 7", active_count); end
    kill1(6);
    nchk++; if (active_count !== 4'd7) begin nfail++; $display("FAIL kill_inactive: got %0d required 7", active_count); end
  endtask

  task automatic test_overrun_kill;
    do_reset;
    for (int k = 0; k < 4; k++) spawn1(10 * k + 10, 50, 1, 0, 0);
    do_tick;               // sweep count 0
    cyc(2);                // sweep count 2
    kill_valid = 1; kill_idx = 3'd2; cyc(1); kill_valid = 0;
    tick = 1; cyc(1); tick = 0;   // tick at sweep count 3
    nchk++; if (overrun !== 1'b1) begin nfail++; $display("FAIL overrun_set: got %0b required 1", overrun); end
    cyc(8);
    rd_idx_b = 3'd3; peek(0);
    nchk++; if (pos_a !== {8'd11, 8'd50}) begin nfail++; $display("FAIL once_slot0: pos %h required 0b32", pos_a); end
    nchk++; if (pos_b !== {8'd41, 8'd50} || active_b !== 1'b1) begin nfail++; $display("FAIL once_slot3_b: pos %h active %0b required 2932/1", pos_b, active_b); end
    peek(1);
    nchk++; if (pos_a !== {8'd21, 8'd50}) begin nfail++; $display("FAIL once_slot1: pos %h required 1532", pos_a); end
    peek(2);
    nchk++; if (active_a !== 1'b0 || pos_a !== {8'd30, 8'd50}) begin nfail++; $display("FAIL kill_in_sweep: active %0b pos %h required 0/1e32", active_a, pos_a); end
    nchk++; if (active_count !== 4'd3 || overrun !== 1'b1) begin nfail++; $display("FAIL overrun_end: count %0d overrun %0b required 3/1", active_count, overrun); end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    do_reset;
    for (int k = 0; k < 3; k++) spawn1(20, 20, 1, 1, 0);
    do_tick; cyc(4);       // sweep count 4
    rd_idx_a = 3'd0; rd_idx_b = 3'd1;
    rst_n = 0; #1;
    nchk++; if (active_a !== 1'b0 || active_b !== 1'b0 || pos_a !== 16'h0) begin nfail++; $display("FAIL mid_rst_slots: active %0b/%0b pos %h required 0/0/0000", active_a, active_b, pos_a); end
    nchk++; if (active_count !== 4'd0 || spawn_ready !== 1'b0) begin nfail++; $display("FAIL mid_rst_ctrl: count %0d ready %0b required 0/0", active_count, spawn_ready); end
    cyc(1); rst_n = 1; cyc(1);
    nchk++; if (spawn_ready !== 1'b1) begin nfail++; $display("FAIL mid_rst_idle: ready %0b required 1", spawn_ready); end
    for (int k = 0; k < N; k++) begin peek(k); if (active_a !== 1'b0) bad++; end
    nchk++; if (bad != 0) begin nfail++; $display("FAIL mid_rst_clear: %0d active slots required 0", bad); end
    spawn1(50, 50, 0, 0, 0); cyc(10); peek(0);
    nchk++; if (pos_a !== {8'd50, 8'd50} || active_count !== 4'd1) begin nfail++; $display("FAIL mid_rst_fresh: pos %h count %0d required 3232/1", pos_a, active_count); end
  endtask

  initial begin
    test_reset;
    test_move;
    test_boundary;
    test_wrap_neg;
    test_full;
    test_overrun_kill;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Parameter N_SLOTS, default 8, number of bullet slots (power of two, 2..32).
REQ-002 Parameter COORD_W, default 8, width of each x/y coordinate and each w/h size field.
REQ-003 Parameter VEL_W, default 5, width of signed two's-complement per-axis velocity.
REQ-004 Parameter X_MAX, default 200, largest legal x coordinate.
REQ-005 Parameter Y_MAX, default 200, largest legal y coordinate.
REQ-006 Parameter IDX_W, default $clog2(N_SLOTS), slot index width.
REQ-007 clk  in  1  single clock; all state changes on rising edge.
REQ-008 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-009 tick  in  1  one-cycle pulse requesting one motion update of all slots.
REQ-010 spawn_valid  in  1  spawn request.
REQ-011 spawn_ready  out  1  spawn accepted this cycle when valid is also high.
REQ-012 spawn_x, spawn_y  in  COORD_W each  initial position.
REQ-013 spawn_w, spawn_h  in  COORD_W each  size.
REQ-014 spawn_vx, spawn_vy  in  VEL_W each  signed velocity per tick.
REQ-015 spawn_color  in  3  000 white, 001 green, 010 blue; others reserved, stored as given.
REQ-016 spawn_wrap  in  1  0 = despawn at boundary, 1 = wrap at boundary.
REQ-017 kill_valid, kill_idx  in  1, IDX_W  deactivate one slot.
REQ-018 rd_idx_a, rd_idx_b  in  IDX_W each  read port A (VGA), read port B (collision/damage).
REQ-019 pos_a, pos_b  out  2*COORD_W  {x,y}; size_a, size_b  out  2*COORD_W  {w,h}; color_a, color_b  out  3; active_a, active_b  out  1.
REQ-020 active_count  out  IDX_W+1  number of active slots; overrun  out  1  sticky missed-tick flag.

Function
REQ-021 Read ports SHALL be combinational from slot storage, each port using only its own index for every field.
REQ-022 FSM states IDLE, SWEEP; IDLE->SWEEP on tick; SWEEP processes slot k at sweep count k, one slot per cycle; SWEEP->IDLE after slot N_SLOTS-1 (N_SLOTS cycles total).
REQ-023 tick arriving in SWEEP SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-024 In SWEEP each active slot: nx = x + sign-extended vx and ny = y + vy, computed at COORD_W+2 bits signed; inactive slots are unchanged.
REQ-025 If nx<0 or nx>X_MAX (same for y vs Y_MAX) and wrap=0, slot SHALL become inactive with position unchanged.
REQ-026 If out of range and wrap=1: nx<0 -> nx+X_MAX+1; nx>X_MAX -> nx-(X_MAX+1); y likewise; slot stays active.
REQ-027 spawn_ready = (state==IDLE) and at least one inactive slot exists; handshake completes on valid&&ready.
REQ-028 Spawn SHALL write the lowest-index inactive slot, set active, visible on read ports the next cycle.
REQ-029 Kill SHALL act in any state; kill of an inactive slot has no effect.
REQ-030 Kill and sweep on the same slot in the same cycle: kill wins, slot inactive.
REQ-031 Kill and spawn in the same cycle: spawn target chosen from pre-kill state; killed slot is not reused that cycle.
REQ-032 active_count SHALL be registered and reflect all spawns, kills and despawns of the previous cycle; net change per cycle in {-2,-1,0,+1}.
REQ-033 spawn_valid may be held while ready is low; the request is not lost or duplicated.

Reset
REQ-034 rst_n low SHALL immediately clear all slot fields and active bits, state=IDLE, sweep count 0, active_count 0, overrun 0, spawn_ready 0 while in reset.
REQ-035 Reset mid-SWEEP SHALL abort the sweep with no partial updates surviving.

Verification
REQ-036 Spawn x=16,y=19,vx=+10,vy=0,wrap=0; tick; wait 8 cycles -> slot0 pos {26,19}, active_count 1.
REQ-037 Slot x=195,vx=+10,wrap=0; tick -> slot inactive after its sweep cycle, active_count decrements; wrap=1 -> x=4.
REQ-038 x=3, vx=-5, wrap=1; tick -> x=199 (X_MAX=200).
REQ-039 Spawn 8 bullets -> spawn_ready 0; kill idx 5 -> next spawn lands in slot 5.
REQ-040 tick at sweep cycle 3 -> overrun=1, positions advanced exactly once; kill slot 2 during its sweep cycle -> slot 2 inactive.
REQ-041 Assert rst_n low at sweep cycle 4 -> all active_* 0, active_count 0, state IDLE immediately.
